// File: rtl/huff_code_packer.sv
// huff_code_packer
//   Packs variable-length Huffman codewords MSB-first into fixed OUT_W-bit
//   words. Ready/valid on both sides; a flush pads the final partial word
//   with zeros, tags it out_last, then pulses flush_done.
// Ports
//   clk, reset_n            clock, async active-low reset
//   in_valid/in_ready       codeword handshake
//   code_value/code_mask    LSB-aligned codeword and contiguous bit mask
//   flush_req               one-cycle drain request (sampled in RUN only)
//   out_valid/out_ready     packed word handshake
//   out_word, out_last      packed word (oldest bit in MSB), padded-final tag
//   flush_done              one-cycle pulse when the flush has drained
//   total_bits              saturating count of accepted code bits
module huff_code_packer #(
  parameter int CODE_W = 3,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code_value,
  input  logic [CODE_W-1:0] code_mask,
  input  logic              flush_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_word,
  output logic              out_last,
  output logic              flush_done,
  output logic [CNT_W-1:0]  total_bits
);

  localparam int AW = OUT_W + CODE_W;
  localparam int FW = $clog2(AW + 1);
  localparam logic [FW-1:0] OUT_W_F = FW'(OUT_W);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W:0]  total_sum;
  logic [FW-1:0]   len;
  logic [AW-1:0]   shifted;
  logic            full, pad, accept, emit;

  always_comb begin
    len = '0;
    for (int unsigned i = 0; i < CODE_W; i++) begin
      len = len + FW'(code_mask[i]);
    end
  end

  assign full   = (fill_q >= OUT_W_F);
  assign pad    = (state_q == DRAIN) && (fill_q != '0) && !full;
  // Gated by reset_n so every output reads 0 while reset is held.
  assign in_ready   = reset_n && (state_q == RUN) && !full;
  assign out_valid  = full || pad;
  assign out_last   = pad;
  assign flush_done = (state_q == DONE);
  assign total_bits = total_q;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  // Full word: right-align acc[fill-1 -: OUT_W]. Partial word: left-justify
  // acc[fill-1:0]. Stale bits above fill fall out of the low OUT_W either way.
  always_comb begin
    if (full) begin
      shifted = acc_q >> (fill_q - OUT_W_F);
    end else begin
      shifted = acc_q << (OUT_W_F - fill_q);
    end
    out_word = shifted[OUT_W-1:0];
  end

  assign total_sum = {1'b0, total_q} + (CNT_W+1)'(len);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    total_d = total_q;
    if (accept) begin
      total_d = total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];
    end
    case (state_q)
      RUN: begin
        if (accept) begin
          acc_d  = (acc_q << len) | AW'(code_value & code_mask);
          fill_d = fill_q + len;
        end else if (emit) begin
          fill_d = fill_q - OUT_W_F;
        end
        if (flush_req) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (full) begin
          if (emit) begin
            fill_d = fill_q - OUT_W_F;
          end
        end else if (fill_q != '0) begin
          if (emit) begin
            fill_d  = '0;
            state_d = DONE;
          end
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        acc_d   = '0;
        fill_d  = '0;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      total_q <= total_d;
    end
  end

endmodule

// File: tb/tb_huff_code_packer.sv
module tb_huff_code_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  code_value = '0;
  logic [2:0]  code_mask = '0;
  logic        flush_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_word;
  logic        out_last;
  logic        flush_done;
  logic [15:0] total_bits;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  huff_code_packer #(.CODE_W(3), .OUT_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .code_value(code_value), .code_mask(code_mask), .flush_req(flush_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_last(out_last), .flush_done(flush_done), .total_bits(total_bits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks that a
  // stalled word does not change.
  logic       prev_stall = 1'b0;
  logic [8:0] prev_pkt = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        chk("stall_stable", {23'b0, out_last, out_word}, {23'b0, prev_pkt});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {23'b0, out_last, out_word}, 32'h1ff);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("pkt_word", {24'b0, out_word}, {24'b0, e[7:0]});
          chk("pkt_last", {31'b0, out_last}, {31'b0, e[8]});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_pkt   = {out_last, out_word};
    end
  end

  task automatic outputs_zero(input string tag);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_out_word"}, {24'b0, out_word}, 32'd0);
    chk({tag, "_out_last"}, {31'b0, out_last}, 32'd0);
    chk({tag, "_flush_done"}, {31'b0, flush_done}, 32'd0);
    chk({tag, "_total"}, {16'b0, total_bits}, 32'd0);
  endtask

  // Leaves the bench aligned at posedge+1.
  task automatic do_reset();
    in_valid = 1'b0; flush_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1 outputs_zero("rst_held");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_total", {16'b0, total_bits}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [2:0] v, input logic [2:0] m, input logic fl);
    int n;
    in_valid = 1'b1; code_value = v; code_mask = m; flush_req = fl;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; flush_req = 1'b0; code_mask = '0; code_value = '0;
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!flush_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_flush_done_seen"}, {31'b0, flush_done}, 32'd1);
    @(negedge clk);
    chk({tag, "_flush_done_pulse"}, {31'b0, flush_done}, 32'd0);
    chk({tag, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle_check(input string tag, input logic [15:0] tot);
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_total"}, {16'b0, total_bits}, {16'b0, tot});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    // 1: 101 | 01 | 110 -> 8'hAE
    out_ready = 1'b1;
    do_reset();
    exp_q.push_back({1'b0, 8'hAE});
    send(3'b101, 3'b111, 1'b0);
    send(3'b001, 3'b011, 1'b0);
    send(3'b110, 3'b111, 1'b0);
    @(posedge clk); #1;
    idle_check("t1", 16'd8);

    // 2: 11 then flush -> 8'hC0 last
    do_reset();
    send(3'b011, 3'b011, 1'b0);
    exp_q.push_back({1'b1, 8'hC0});
    pulse_flush();
    wait_done("t2");
    chk("t2_total", {16'b0, total_bits}, 32'd2);

    // 3: nine 1s with sink stalled
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'hFF});
    send(3'b111, 3'b111, 1'b0);
    send(3'b111, 3'b111, 1'b0);
    send(3'b111, 3'b111, 1'b0);
    chk("t3_in_ready_full", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_valid", {31'b0, out_valid}, 32'd1);
      chk("t3_stall_word", {24'b0, out_word}, 32'hFF);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    idle_check("t3", 16'd9);
    exp_q.push_back({1'b1, 8'h80});
    pulse_flush();
    wait_done("t3");

    // 4: flush while empty
    do_reset();
    flush_req = 1'b1;
    @(negedge clk);
    chk("t4_fd_c0", {31'b0, flush_done}, 32'd0);
    @(posedge clk); #1;
    flush_req = 1'b0;
    @(negedge clk);
    chk("t4_fd_c1", {31'b0, flush_done}, 32'd0);
    chk("t4_ov_c1", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("t4_fd_c2", {31'b0, flush_done}, 32'd1);
    chk("t4_ov_c2", {31'b0, out_valid}, 32'd0);
    chk("t4_ir_c2", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("t4_fd_c3", {31'b0, flush_done}, 32'd0);
    chk("t4_ir_c3", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // 5: zero-mask code, then 2-bit code with flush in the same cycle
    do_reset();
    send(3'b010, 3'b000, 1'b0);
    idle_check("t5_zero", 16'd0);
    exp_q.push_back({1'b1, 8'h80});
    send(3'b010, 3'b011, 1'b1);
    wait_done("t5");
    chk("t5_total", {16'b0, total_bits}, 32'd2);

    // 6: reset while a padded word is pending
    do_reset();
    out_ready = 1'b0;
    send(3'b111, 3'b111, 1'b0);
    send(3'b001, 3'b011, 1'b0);
    pulse_flush();
    @(negedge clk);
    chk("t6_pend_valid", {31'b0, out_valid}, 32'd1);
    chk("t6_pend_last", {31'b0, out_last}, 32'd1);
    chk("t6_pend_word", {24'b0, out_word}, 32'hE8);
    #2 reset_n = 1'b0;
    #1 outputs_zero("t6_async");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_word", {31'b0, out_valid}, 32'd0);
      chk("t6_no_done", {31'b0, flush_done}, 32'd0);
    end
    chk("t6_total", {16'b0, total_bits}, 32'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
